// File: rtl/spi_slave_multichan.sv
// SPI receive slave carrying NCH channel words per frame plus an 8-bit XOR checksum.
// All SPI pins are asynchronous and are resynchronised into clk before use. A
// checked frame lands in a pending buffer and is released to rx_out, all channels
// at once, by the update pulse.
module spi_slave_multichan #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   SCK,
   input  logic                   SSEL,
   input  logic                   DATA_IN,
   input  logic                   update,
   output logic [NCH*WIDTH-1:0]   rx_out,
   output logic                   rdy,
   output logic                   frame_err,
   output logic [15:0]            frame_cnt,
   output logic [15:0]            err_cnt
);

   localparam int unsigned NBITS     = NCH * WIDTH;
   localparam int unsigned FRAME_LEN = NBITS + 8;
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

   localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] NBITS_C = CNT_W'(NBITS);

   // Elaboration-time parameter sanity
   if ((NBITS % 8) != 0) begin : g_chk_bytes
      $error("spi_slave_multichan: NCH*WIDTH must be a multiple of 8");
   end
   if ((NCH < 1) || (NCH > 16)) begin : g_chk_nch
      $error("spi_slave_multichan: NCH must be in 1..16");
   end
   if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_chk_sync
      $error("spi_slave_multichan: SYNC_STAGES must be in 2..4");
   end

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StCheck
   } state_e;

   // ------------------------------------------------------------------
   // Synchronizers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] ssel_sync_q;
   logic [SYNC_STAGES-1:0] din_sync_q;
   // Marks which synchronizer stages hold real pin samples since reset.
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   sck_prev_q;
   logic                   ssel_prev_q;
   // Set once SSEL has truly been seen high after reset; a frame already in
   // flight at reset release must not look like a fresh falling edge.
   logic                   ssel_armed_q;

   logic sck_s;
   logic ssel_s;
   logic din_s;
   logic sync_filled;
   logic sck_rise;
   logic ssel_rise;
   logic ssel_fall;

   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign ssel_s      = ssel_sync_q[SYNC_STAGES-1];
   assign din_s       = din_sync_q[SYNC_STAGES-1];
   assign sync_filled = fill_q[SYNC_STAGES-1];

   assign sck_rise  = sck_s & ~sck_prev_q;
   assign ssel_rise = ssel_s & ~ssel_prev_q;
   assign ssel_fall = ~ssel_s & ssel_prev_q & ssel_armed_q;

   // Resynchronise the SPI pins and keep one-cycle-old copies for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q   <= '0;
         ssel_sync_q  <= '1;
         din_sync_q   <= '0;
         fill_q       <= '0;
         sck_prev_q   <= 1'b0;
         ssel_prev_q  <= 1'b1;
         ssel_armed_q <= 1'b0;
      end else begin
         sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
         ssel_sync_q  <= {ssel_sync_q[SYNC_STAGES-2:0], SSEL};
         din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], DATA_IN};
         fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         sck_prev_q   <= sck_s;
         ssel_prev_q  <= ssel_s;
         ssel_armed_q <= ssel_armed_q | (sync_filled & ssel_s);
      end
   end

   // ------------------------------------------------------------------
   // Receive FSM and shift datapath
   // ------------------------------------------------------------------
   state_e             state_q, state_d;
   logic [NBITS-1:0]   shadow_q, shadow_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   // Running XOR over payload and checksum bytes; zero means the checksum matches.
   logic [7:0]         chk_q, chk_d;
   logic               overlong_q, overlong_d;
   logic               frame_ok;
   logic               commit;
   logic               reject;

   assign frame_ok = (bit_cnt_q == LEN_C) && !overlong_q && (chk_q == 8'h00);

   // Next-state logic: frame start, bit capture, end-of-frame evaluation
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      bit_cnt_d  = bit_cnt_q;
      chk_d      = chk_q;
      overlong_d = overlong_q;
      commit     = 1'b0;
      reject     = 1'b0;

      if (!en) begin
         // Silent abort: no pulse, no count change
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ssel_fall) begin
                  state_d    = StShift;
                  bit_cnt_d  = '0;
                  chk_d      = 8'h00;
                  overlong_d = 1'b0;
               end
            end
            StShift: begin
               if (sck_rise) begin
                  if (bit_cnt_q < LEN_C) begin
                     // Bit k of the stream is bit (7 - k%8) of its byte, MSB first
                     chk_d[~bit_cnt_q[2:0]] = chk_q[~bit_cnt_q[2:0]] ^ din_s;
                     if (bit_cnt_q < NBITS_C) begin
                        shadow_d = {shadow_q[NBITS-2:0], din_s};
                     end
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end else begin
                     overlong_d = 1'b1;
                  end
               end
               if (ssel_rise) begin
                  state_d = StCheck;
               end
            end
            StCheck: begin
               state_d = StIdle;
               if (frame_ok) begin
                  commit = 1'b1;
               end else begin
                  reject = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM state and shift datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         shadow_q   <= '0;
         bit_cnt_q  <= '0;
         chk_q      <= 8'h00;
         overlong_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         bit_cnt_q  <= bit_cnt_d;
         chk_q      <= chk_d;
         overlong_q <= overlong_d;
      end
   end

   // ------------------------------------------------------------------
   // Pending buffer, output release and statistics
   // ------------------------------------------------------------------
   // Channel 0 arrives first so it sits at the top of the shift register;
   // swap channel order so channel 0 lands in the low word.
   logic [NBITS-1:0] shadow_ordered;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_reorder
      assign shadow_ordered[gi*WIDTH +: WIDTH] = shadow_q[(NCH-1-gi)*WIDTH +: WIDTH];
   end

   logic [NBITS-1:0] pending_q, pending_d;
   logic             pending_valid_q, pending_valid_d;
   logic [NBITS-1:0] rx_out_q, rx_out_d;
   logic             rdy_q, frame_err_q;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [15:0]      err_cnt_q, err_cnt_d;

   // Release happens before commit so a coincident commit stays pending
   always_comb begin
      pending_d       = pending_q;
      pending_valid_d = pending_valid_q;
      rx_out_d        = rx_out_q;
      frame_cnt_d     = frame_cnt_q;
      err_cnt_d       = err_cnt_q;

      if (update && pending_valid_q) begin
         rx_out_d        = pending_q;
         pending_valid_d = 1'b0;
      end
      if (commit) begin
         pending_d       = shadow_ordered;
         pending_valid_d = 1'b1;
         frame_cnt_d     = frame_cnt_q + 16'd1;
      end
      if (reject && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Output-side registers: buffers, pulses and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         rx_out_q        <= '0;
         rdy_q           <= 1'b0;
         frame_err_q     <= 1'b0;
         frame_cnt_q     <= 16'd0;
         err_cnt_q       <= 16'd0;
      end else begin
         pending_q       <= pending_d;
         pending_valid_q <= pending_valid_d;
         rx_out_q        <= rx_out_d;
         rdy_q           <= commit;
         frame_err_q     <= reject;
         frame_cnt_q     <= frame_cnt_d;
         err_cnt_q       <= err_cnt_d;
      end
   end

   assign rx_out    = rx_out_q;
   assign rdy       = rdy_q;
   assign frame_err = frame_err_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_spi_slave_multichan.sv
// Scoreboard bench for spi_slave_multichan with NCH=2, WIDTH=32.
module tb_spi_slave_multichan;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b1;
   logic        SCK = 1'b0;
   logic        SSEL = 1'b1;
   logic        DATA_IN = 1'b0;
   logic        update = 1'b0;
   logic [63:0] rx_out;
   logic        rdy;
   logic        frame_err;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_rdy;
      logic [15:0] fc;
      logic [15:0] ec;
   } evt_t;

   evt_t        exp_evt[$];
   logic [63:0] exp_rx[$];
   logic [63:0] last_rx = '0;

   // Streams are {ch0, ch1, checksum}, sent MSB first
   localparam logic [71:0] FRAME_A     = {32'h3F800000, 32'h40000000, 8'hFF};
   localparam logic [71:0] FRAME_A_BAD = {32'h3F800000, 32'h40000000, 8'hFE};
   localparam logic [71:0] FRAME_B     = {32'h12345678, 32'h9ABCDEF0, 8'h00};
   localparam logic [71:0] FRAME_C     = {32'hDEADBEEF, 32'h00000001, 8'h23};
   localparam logic [71:0] FRAME_D     = {32'h00000080, 32'h01000000, 8'h81};
   // rx_out images {ch1, ch0}
   localparam logic [63:0] RX_A = {32'h40000000, 32'h3F800000};
   localparam logic [63:0] RX_B = {32'h9ABCDEF0, 32'h12345678};
   localparam logic [63:0] RX_C = {32'h00000001, 32'hDEADBEEF};
   localparam logic [63:0] RX_D = {32'h01000000, 32'h00000080};

   spi_slave_multichan #(
      .NCH        (2),
      .WIDTH      (32),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .SCK      (SCK),
      .SSEL     (SSEL),
      .DATA_IN  (DATA_IN),
      .update   (update),
      .rx_out   (rx_out),
      .rdy      (rdy),
      .frame_err(frame_err),
      .frame_cnt(frame_cnt),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT pulses or changes rx_out
   always @(negedge clk) begin : monitor
      evt_t e;
      if (reset) begin
         last_rx = rx_out;
      end else begin
         if (rdy || frame_err) begin
            if (exp_evt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: rdy=%0b frame_err=%0b with none expected",
                        rdy, frame_err);
            end else begin
               e = exp_evt.pop_front();
               check("event_kind", 64'({rdy, frame_err}), e.is_rdy ? 64'd2 : 64'd1);
               check("frame_cnt", 64'(frame_cnt), 64'(e.fc));
               check("err_cnt", 64'(err_cnt), 64'(e.ec));
            end
         end
         if (rx_out !== last_rx) begin
            if (exp_rx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rx_out: got %h, no change expected (was %h)",
                        rx_out, last_rx);
            end else begin
               check("rx_out", rx_out, exp_rx.pop_front());
            end
            last_rx = rx_out;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_evt(input bit is_rdy, input logic [15:0] fc, input logic [15:0] ec);
      evt_t e;
      e.is_rdy = is_rdy;
      e.fc     = fc;
      e.ec     = ec;
      exp_evt.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      cyc(4);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_rx_out"}, rx_out, 64'd0);
      check({tag, "_rdy"}, 64'(rdy), 64'd0);
      check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
   endtask

   task automatic shift_bits(input logic [71:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         DATA_IN = (i < 72) ? s[71-i] : 1'b0;
         cyc(3);
         SCK = 1'b1;
         cyc(3);
         SCK = 1'b0;
      end
   endtask

   task automatic send(input logic [71:0] s, input int n);
      SSEL = 1'b0;
      cyc(4);
      shift_bits(s, n);
      cyc(3);
      SSEL = 1'b1;
      cyc(8);
   endtask

   task automatic pulse_update();
      update = 1'b1;
      cyc(1);
      update = 1'b0;
      cyc(3);
   endtask

   task automatic scenario_end(input string tag);
      cyc(4);
      check({tag, "_events_left"}, 64'(exp_evt.size()), 64'd0);
      check({tag, "_rx_left"}, 64'(exp_rx.size()), 64'd0);
   endtask

   initial begin
      cyc(2);

      // Valid frame, then release
      do_reset();
      reset_checks("reset");
      push_evt(1'b1, 16'd1, 16'd0);
      send(FRAME_A, 72);
      exp_rx.push_back(RX_A);
      pulse_update();
      scenario_end("valid");

      // Bad checksum: rejected, nothing to release
      do_reset();
      reset_checks("reset2");
      push_evt(1'b0, 16'd0, 16'd1);
      send(FRAME_A_BAD, 72);
      pulse_update();
      check("badchk_rx_out", rx_out, 64'd0);
      scenario_end("badchk");

      // Short (40 bits) then overlong (73 bits)
      do_reset();
      push_evt(1'b0, 16'd0, 16'd1);
      send(FRAME_A, 40);
      push_evt(1'b0, 16'd0, 16'd2);
      send(FRAME_A, 73);
      pulse_update();
      check("len_rx_out", rx_out, 64'd0);
      check("len_err_cnt", 64'(err_cnt), 64'd2);
      scenario_end("len");

      // Latest pending frame wins; second update is a no-op
      do_reset();
      push_evt(1'b1, 16'd1, 16'd0);
      send(FRAME_A, 72);
      push_evt(1'b1, 16'd2, 16'd0);
      send(FRAME_B, 72);
      exp_rx.push_back(RX_B);
      pulse_update();
      pulse_update();
      check("overwrite_rx_out", rx_out, RX_B);
      scenario_end("overwrite");

      // Commit of B coincides with update releasing A
      do_reset();
      push_evt(1'b1, 16'd1, 16'd0);
      send(FRAME_A, 72);
      push_evt(1'b1, 16'd2, 16'd0);
      exp_rx.push_back(RX_A);
      SSEL = 1'b0;
      cyc(4);
      shift_bits(FRAME_B, 72);
      cyc(3);
      SSEL = 1'b1;
      // Two sync stages plus the edge register put CHECK in the third cycle
      cyc(3);
      update = 1'b1;
      cyc(1);
      update = 1'b0;
      cyc(8);
      check("coincide_rx_a", rx_out, RX_A);
      exp_rx.push_back(RX_B);
      pulse_update();
      scenario_end("coincide");

      // Reset mid-frame with SSEL still low, then a full frame
      SSEL = 1'b0;
      cyc(4);
      shift_bits(FRAME_C, 20);
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      cyc(6);
      SSEL = 1'b1;
      cyc(6);
      reset_checks("midreset");
      push_evt(1'b1, 16'd1, 16'd0);
      send(FRAME_C, 72);
      exp_rx.push_back(RX_C);
      pulse_update();

      // en dropped mid-frame: silent abort
      SSEL = 1'b0;
      cyc(4);
      shift_bits(FRAME_D, 20);
      en = 1'b0;
      cyc(4);
      SSEL = 1'b1;
      cyc(6);
      en = 1'b1;
      cyc(4);
      check("abort_frame_cnt", 64'(frame_cnt), 64'd1);
      check("abort_err_cnt", 64'(err_cnt), 64'd0);
      check("abort_rx_out", rx_out, RX_C);
      push_evt(1'b1, 16'd2, 16'd0);
      send(FRAME_D, 72);
      exp_rx.push_back(RX_D);
      pulse_update();
      scenario_end("abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_multichan.md
SPI_SLAVE_MULTICHAN -- requirements
Module: spi_slave_multichan

Interface
REQ-001 SHALL have parameter NCH, default 4, number of 32-bit-style channels carried per frame (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, bits per channel word; NCH*WIDTH SHALL be a multiple of 8 (elaboration error otherwise).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for SCK/SSEL/DATA_IN (2..4).
REQ-004 SHALL have port clk  input  1  system clock (clk1); sole clock of the block.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  receive enable.
REQ-007 SHALL have port SCK  input  1  asynchronous serial clock from the remote board pin.
REQ-008 SHALL have port SSEL  input  1  asynchronous active-low frame select.
REQ-009 SHALL have port DATA_IN  input  1  asynchronous serial data (MOSI).
REQ-010 SHALL have port update  input  1  one-cycle pulse in clk domain (sim_clk tick edge) releasing pending frame to outputs.
REQ-011 SHALL have port rx_out  output  NCH*WIDTH  channel words; channel 0 in bits [WIDTH-1:0].
REQ-012 SHALL have port rdy  output  1  one-cycle pulse: valid frame committed to pending buffer.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse: frame rejected.
REQ-014 SHALL have port frame_cnt  output  16  count of valid frames, wraps.
REQ-015 SHALL have port err_cnt  output  16  count of rejected frames, saturates at 0xFFFF.

Function
REQ-016 SHALL pass SCK, SSEL, DATA_IN through SYNC_STAGES flops before any use; edges detected on synchronized values only.
REQ-017 SHALL implement states IDLE, SHIFT, CHECK.
REQ-018 IDLE -> SHIFT on synchronized SSEL falling edge while en=1; bit counter and checksum accumulator cleared.
REQ-019 In SHIFT, each synchronized SCK rising edge SHALL shift DATA_IN in, MSB first, channel 0 first, and increment the bit counter.
REQ-020 Frame length SHALL be NCH*WIDTH payload bits followed by 8 checksum bits; checksum = XOR of all payload bytes.
REQ-021 Bits beyond NCH*WIDTH+8 SHALL NOT be shifted in; they mark the frame overlong.
REQ-022 SHIFT -> CHECK on synchronized SSEL rising edge (cycle T).
REQ-023 In CHECK (cycle T+1): if bit count == NCH*WIDTH+8, not overlong, and checksum matches, SHALL copy shadow into pending buffer, set pending_valid, pulse rdy, increment frame_cnt; else SHALL pulse frame_err, increment err_cnt, leave pending untouched; then -> IDLE.
REQ-024 Short frame (SSEL rises mid-word) SHALL be rejected per REQ-023.
REQ-025 On update=1 with pending_valid=1, rx_out SHALL load pending on the next edge and pending_valid clear; update with pending_valid=0 SHALL leave rx_out unchanged.
REQ-026 Commit and update in the same cycle: rx_out SHALL load the old pending content (if valid); new frame SHALL remain pending, pending_valid=1.
REQ-027 A second valid frame before update SHALL overwrite pending (latest wins); no error.
REQ-028 en=0 SHALL force IDLE, abort any frame in progress without error pulse or count change; rx_out and pending retained.
REQ-029 All channels in rx_out SHALL change in the same cycle (no partial-frame visibility).

Reset
REQ-030 On reset: state IDLE; rx_out, pending, shadow all 0; pending_valid 0; rdy 0; frame_err 0; frame_cnt 0; err_cnt 0; synchronizer flops SSEL=1, SCK=0, DATA_IN=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release, bits resume counting only after a fresh SSEL falling edge.

Verification (NCH=2, WIDTH=32)
REQ-032 Frame 0x3F800000, 0x40000000, checksum 0xFF, then update -> rdy pulse once, frame_cnt=1, rx_out[31:0]=0x3F800000, rx_out[63:32]=0x40000000.
REQ-033 Same frame with checksum 0xFE -> frame_err pulse, err_cnt=1, frame_cnt=0, rx_out stays 0 after update.
REQ-034 SSEL released after 40 bits; then separately 73 bits -> two frame_err pulses, err_cnt=2, pending_valid 0.
REQ-035 Valid frame A committed, valid frame B committed, then update -> rx_out = B; update again -> rx_out unchanged.
REQ-036 Commit of frame B coincident with update while A pending -> rx_out = A that cycle+1, B released on next update.
REQ-037 Reset pulse after 20 bits, then full valid frame -> single rdy, frame_cnt=1, correct rx_out; en=0 mid-frame -> no rdy, no frame_err.
